// File: rtl/snake_text_pkg.sv
// rtl/snake_text_pkg.sv - shared constants and message lookup for the overlay text glyph server
// Purpose: character codes, message lengths, cell and font geometry, message character lookup.
// Ports: none (package).
package snake_text_pkg;

    localparam int CELL_SIZE = 80;
    localparam int FONT_W    = 8;
    localparam int FONT_H    = 16;

    localparam logic [3:0] GAME_OVER_LEN = 4'd9;
    localparam logic [3:0] YOU_WIN_LEN   = 4'd7;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_G     = 8'h47;
    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_N     = 8'h4E;
    localparam logic [7:0] CH_O     = 8'h4F;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_Y     = 8'h59;

    typedef enum logic {
        MSG_GAME_OVER = 1'b0,
        MSG_YOU_WIN   = 1'b1
    } msg_e;

    // Character shown in column col of the selected message; space past the end.
    function automatic logic [7:0] msg_char(input msg_e sel, input logic [3:0] col);
        logic [7:0] c;
        c = CH_SPACE;
        if (sel == MSG_GAME_OVER) begin
            if (col < GAME_OVER_LEN) begin
                case (col)
                    4'd0:    c = CH_G;
                    4'd1:    c = CH_A;
                    4'd2:    c = CH_M;
                    4'd3:    c = CH_E;
                    4'd5:    c = CH_O;
                    4'd6:    c = CH_V;
                    4'd7:    c = CH_E;
                    4'd8:    c = CH_R;
                    default: c = CH_SPACE;
                endcase
            end
        end else begin
            if (col < YOU_WIN_LEN) begin
                case (col)
                    4'd0:    c = CH_Y;
                    4'd1:    c = CH_O;
                    4'd2:    c = CH_U;
                    4'd4:    c = CH_W;
                    4'd5:    c = CH_I;
                    4'd6:    c = CH_N;
                    default: c = CH_SPACE;
                endcase
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/text_glyph_server_if.sv
// rtl/text_glyph_server_if.sv - request/response bundle between overlay stage and glyph server
// Purpose: groups the cell request, frame sync, message select and glyph row response.
// Signals: char_yx, char_line, vsync_in, msg_sel (overlay -> server);
//          char_pixels, msg_active (server -> overlay).
// Modports: master = overlay stage, slave = glyph server.
interface text_glyph_server_if;

    logic [7:0]                           char_yx;
    logic [7:0]                           char_line;
    logic                                 vsync_in;
    logic                                 msg_sel;
    logic [snake_text_pkg::CELL_SIZE-1:0] char_pixels;
    logic                                 msg_active;

    modport master (
        output char_yx, char_line, vsync_in, msg_sel,
        input  char_pixels, msg_active
    );

    modport slave (
        input  char_yx, char_line, vsync_in, msg_sel,
        output char_pixels, msg_active
    );

endinterface

// File: rtl/font_rom_8x16.sv
// rtl/font_rom_8x16.sv - registered 8x16 font ROM for the message glyphs
// Purpose: synchronous read of one 8-bit font row; its output register is pipeline stage 2.
// Ports: pclk, rst_n (async active-low), clr (load zero row instead of ROM data),
//        addr = {char_code[6:0], font_row[3:0]}, data = registered font row (bit 7 leftmost).
module font_rom_8x16
    import snake_text_pkg::*;
(
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [10:0]       addr,
    output logic [FONT_W-1:0] data
);

    logic [FONT_W*FONT_H-1:0] glyph;
    logic [3:0]               row_inv;
    logic [FONT_W-1:0]        row_sel;

    // Glyph bitmaps hold row 0 in the most significant byte. Codes without a
    // bitmap (space included) read as an all-zero glyph.
    always_comb begin
        glyph = '0;
        case (addr[10:4])
            CH_A[6:0]: glyph = 128'h000010386CC6C6FEC6C6C6C600000000;
            CH_E[6:0]: glyph = 128'h0000FE6662687868606266FE00000000;
            CH_G[6:0]: glyph = 128'h00003C66C2C0C0DEC6C6663A00000000;
            CH_I[6:0]: glyph = 128'h00003C18181818181818183C00000000;
            CH_M[6:0]: glyph = 128'h0000C6EEFEFED6C6C6C6C6C600000000;
            CH_N[6:0]: glyph = 128'h0000C6E6F6FEDECEC6C6C6C600000000;
            CH_O[6:0]: glyph = 128'h00007CC6C6C6C6C6C6C6C67C00000000;
            CH_R[6:0]: glyph = 128'h0000FC6666667C6C666666E600000000;
            CH_U[6:0]: glyph = 128'h0000C6C6C6C6C6C6C6C6C67C00000000;
            CH_V[6:0]: glyph = 128'h0000C6C6C6C6C6C6C66C381000000000;
            CH_W[6:0]: glyph = 128'h0000C6C6C6C6D6D6D6FEEE6C00000000;
            CH_Y[6:0]: glyph = 128'h0000666666663C181818183C00000000;
            default:   glyph = '0;
        endcase
        row_inv = 4'(FONT_H - 1) - addr[3:0];
        row_sel = glyph[{row_inv, 3'b000} +: FONT_W];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else begin
            data <= row_sel;
        end
    end

endmodule

// File: rtl/text_glyph_server.sv
// rtl/text_glyph_server.sv - scaled text glyph responder for the game-over/victory overlay
// Purpose: returns the 80-bit pixel row for (char_yx, char_line) exactly 2 pclk later,
//          from an 8x16 font scaled xSCALE_X horizontally and xSCALE_Y vertically.
// Ports: pclk, rst_n (async active-low), bus (text_glyph_server_if.slave):
//        char_yx/char_line request, vsync_in frame sync, msg_sel message choice,
//        char_pixels scaled row (bit 79 leftmost), msg_active latched message.
// Option: TEXT_GLYPH_BLINK_EN adds a vsync-driven blink that blanks the text
//         every other BLINK_PERIOD frames.
module text_glyph_server
    import snake_text_pkg::*;
#(
    parameter int SCALE_X = 10,
    parameter int SCALE_Y = 5
`ifdef TEXT_GLYPH_BLINK_EN
    ,
    parameter int BLINK_PERIOD = 30
`endif
) (
    input  logic               pclk,
    input  logic               rst_n,
    text_glyph_server_if.slave bus
);

    logic              vsync_q;
    logic              vsync_rise;
    logic              msg_active_q;
    logic [7:0]        char_code_d;
    logic [7:0]        char_code_q;
    logic [3:0]        font_row_d;
    logic [3:0]        font_row_q;
    logic              blink_phase;
    logic              rom_clr;
    logic [FONT_W-1:0] rom_row;

    assign vsync_rise     = bus.vsync_in & ~vsync_q;
    assign bus.msg_active = msg_active_q;

    // The message only changes on a frame boundary, so a mid-frame msg_sel
    // change cannot tear the text. A request in the rise cycle still sees the
    // old message because stage 1 reads msg_active_q before it updates.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            msg_active_q <= 1'b0;
        end else begin
            vsync_q <= bus.vsync_in;
            if (vsync_rise) begin
                msg_active_q <= bus.msg_sel;
            end
        end
    end

    // Stage 1: character code and font row. Lines past the cell clamp to the last font row.
    always_comb begin
        char_code_d = CH_SPACE;
        if (bus.char_yx[7:4] == 4'd0) begin
            char_code_d = msg_char(msg_e'(msg_active_q), bus.char_yx[3:0]);
        end
        if (bus.char_line >= 8'(FONT_H * SCALE_Y)) begin
            font_row_d = 4'(FONT_H - 1);
        end else begin
            font_row_d = 4'(bus.char_line / 8'(SCALE_Y));
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            char_code_q <= 8'h00;
            font_row_q  <= 4'h0;
        end else begin
            char_code_q <= char_code_d;
            font_row_q  <= font_row_d;
        end
    end

`ifdef TEXT_GLYPH_BLINK_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (vsync_rise) begin
            if (frame_cnt == 8'(BLINK_PERIOD - 1)) begin
                frame_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    assign blink_phase = 1'b0;
`endif

    // Codes above 0x7F have no glyph; they and the blink-off phase load a blank row.
    assign rom_clr = blink_phase | char_code_q[7];

    // Stage 2: the ROM output register.
    font_rom_8x16 u_font (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (rom_clr),
        .addr  ({char_code_q[6:0], font_row_q}),
        .data  (rom_row)
    );

    // Font bit b drives output bits [b*SCALE_X +: SCALE_X], so font bit 7 lands leftmost.
    always_comb begin
        bus.char_pixels = '0;
        for (int b = 0; b < FONT_W; b++) begin
            bus.char_pixels[b*SCALE_X +: SCALE_X] = {SCALE_X{rom_row[b]}};
        end
    end

endmodule
